// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined carry-lookahead add/sub ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    ADC = 2'd1,
    SUB = 2'd2,
    SBB = 2'd3
  } op_e;

  localparam int FLAG_C  = 3;
  localparam int FLAG_V  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 0;

  localparam int GROUP_W = 4;

endpackage

// File: rtl/cla_group.sv
// 4-bit carry-lookahead group: every internal carry is a two-level function of g/p/cin.
// Combinational, exports group generate/propagate for the next lookahead level.
module cla_group
  import alu_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               G,
  output logic               P,
  output logic               cout
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign G    = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign P    = &prop;
  assign cout = G | (P & cin);

  assign sum  = prop ^ c;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage add/sub: low half + lookahead in stage 1, high half + flags in stage 2; latency 2.
// valid/ready on both sides; in_ready depends only on out_ready and pipeline occupancy.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / GROUP;

  // Carries into each group (and out of the half) as flat sum-of-products of group G/P.
  function automatic logic [NG:0] lookahead(input logic [NG-1:0] g, input logic [NG-1:0] p,
                                            input logic c_in);
    logic [NG:0] c;
    logic        acc;
    logic        pp;
    c[0] = c_in;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[k+1] = acc | (pp & c_in);
    end
    return c;
  endfunction

  logic             s1_vld;
  logic [HALF-1:0]  s1_sum_lo;
  logic             s1_c_lo;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_b_hi;
  op_e              s1_op;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  logic [NG-1:0]    lo_g, lo_p, lo_cout, hi_g, hi_p, hi_cout;
  logic [NG:0]      lo_c, hi_c;
  logic [HALF-1:0]  lo_sum, hi_sum;

  logic             is_sub;
  logic             a_sign, b_sign, r_sign, ovf;
  logic [WIDTH-1:0] res;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_vld || s2_adv;
  assign in_ready = s1_adv;

  assign bx = op[1] ? ~b : b;
  assign c0 = op[0] ? cin : op[1];

  assign lo_c = lookahead(lo_g, lo_p, c0);
  assign hi_c = lookahead(hi_g, hi_p, s1_c_lo);

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_group u_lo (
      .a    (a[i*GROUP_W +: GROUP_W]),
      .b    (bx[i*GROUP_W +: GROUP_W]),
      .cin  (lo_c[i]),
      .sum  (lo_sum[i*GROUP_W +: GROUP_W]),
      .G    (lo_g[i]),
      .P    (lo_p[i]),
      .cout (lo_cout[i])
    );
    cla_group u_hi (
      .a    (s1_a_hi[i*GROUP_W +: GROUP_W]),
      .b    (s1_b_hi[i*GROUP_W +: GROUP_W]),
      .cin  (hi_c[i]),
      .sum  (hi_sum[i*GROUP_W +: GROUP_W]),
      .G    (hi_g[i]),
      .P    (hi_p[i]),
      .cout (hi_cout[i])
    );
  end

  // Group-local carry-outs must agree with the cross-group lookahead network.
  assert property (@(posedge clk) disable iff (!rst_n)
                   {lo_cout, hi_cout} == {lo_c[NG:1], hi_c[NG:1]});

  // s1_b_hi holds ~b for SUB/SBB, so flip its sign back to get the true operand sign.
  assign is_sub = (s1_op == SUB) || (s1_op == SBB);
  assign a_sign = s1_a_hi[HALF-1];
  assign b_sign = s1_b_hi[HALF-1] ^ is_sub;
  assign r_sign = hi_sum[HALF-1];
  assign ovf    = is_sub ? ((a_sign != b_sign) && (r_sign != a_sign))
                         : ((a_sign == b_sign) && (r_sign != a_sign));
  assign res    = {hi_sum, s1_sum_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_sum_lo <= '0;
      s1_c_lo   <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_op     <= ADD;
    end else if (s1_adv) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_sum_lo <= lo_sum;
        s1_c_lo   <= lo_c[NG];
        s1_a_hi   <= a[WIDTH-1:HALF];
        s1_b_hi   <= bx[WIDTH-1:HALF];
        s1_op     <= op_e'(op);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      flags     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        sum           <= res;
        flags[FLAG_C] <= hi_c[NG];
        flags[FLAG_V] <= ovf;
        flags[FLAG_Z] <= (res == '0);
        flags[FLAG_N] <= res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed vectors and a scoreboarded random stream for the 8-bit pipelined add/sub.
module tb_pipelined_cla_addsub;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic [3:0] flags;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];

  pipelined_cla_addsub #(.WIDTH(8), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {C,V,Z,N, sum}
  function automatic logic [11:0] model(input logic [1:0] o, input logic [7:0] x,
                                        input logic [7:0] y, input logic ci);
    logic [7:0] yx;
    logic       c_in;
    logic [8:0] full;
    logic       v;
    yx   = o[1] ? ~y : y;
    c_in = o[0] ? ci : o[1];
    full = {1'b0, x} + {1'b0, yx} + {8'b0, c_in};
    v    = (x[7] == yx[7]) && (full[7] != x[7]);
    return {full[8], v, (full[7:0] == 8'h00), full[7], full[7:0]};
  endfunction

  task automatic drive(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic ci);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    cin = ci;
  endtask

  // Call at posedge+1 with the pipeline free and out_ready=1.
  task automatic run_one(input string tag, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic ci,
                         input logic [7:0] es, input logic [3:0] ef);
    drive(o, x, y, ci);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_flags"}, flags, ef);
  endtask

  task automatic score(input string tag);
    logic [11:0] e;
    if (in_valid && in_ready) exp_q.push_back(model(op, a, b, cin));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check({tag, "_extra"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_sum"}, sum, e[7:0]);
        check({tag, "_flags"}, flags, e[11:8]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    op = ADD;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", flags, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // flags are {C,V,Z,N}
    run_one("add_ff_01", ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
    run_one("sub_80_01", SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1100);
    run_one("sub_00_01", SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0001);
    run_one("adc_7f_00", ADC, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0101);
    run_one("sbb_05_03", SBB, 8'h05, 8'h03, 1'b0, 8'h01, 4'b1000);
    run_one("add_cin_ign", ADD, 8'h10, 8'h01, 1'b1, 8'h11, 4'b0000);

    // Backpressure: two ops fill the pipe, the third is refused.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(ADD, 8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    drive(ADD, 8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    drive(SUB, 8'h03, 8'h03, 1'b0);
    check("bp_full_ready", in_ready, 0);
    check("bp_first_vld", out_valid, 1);
    check("bp_first_sum", sum, 8'h03);
    @(posedge clk); #1;
    check("bp_hold_sum", sum, 8'h03);
    check("bp_hold_flags", flags, 4'b0000);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_sum", sum, 8'h30);
    check("bp_second_vld", out_valid, 1);
    @(posedge clk); #1;
    check("bp_third_sum", sum, 8'h00);
    check("bp_third_flags", flags, 4'b1010);
    @(posedge clk); #1;
    check("bp_empty", out_valid, 0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    drive(ADD, 8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    drive(ADD, 8'h33, 8'h44, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mr_full_vld", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_vld", out_valid, 0);
    check("mr_async_sum", sum, 0);
    check("mr_async_flags", flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_no_ghost", out_valid, 0);
    run_one("mr_add_40_40", ADD, 8'h40, 8'h40, 1'b0, 8'h80, 4'b0101);
    @(posedge clk); #1;
    check("mr_flush", out_valid, 0);

    // Random traffic with random stalls on both sides.
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      op        = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      score("rnd");
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      score("drain");
      @(posedge clk); #1;
    end
    check("rnd_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width; legal values are multiples of 8 from 8 to 64.
REQ-002 The block SHALL have parameter GROUP, default 4, lookahead group width; it is fixed at 4 in this release.
REQ-003 Port clk, input, 1 bit, is the single clock; all state is rising-edge triggered.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit, means the operands and op are presented.
REQ-006 Port in_ready, output, 1 bit, means the block accepts input this cycle.
REQ-007 Port a, input, WIDTH bits, is operand A.
REQ-008 Port b, input, WIDTH bits, is operand B.
REQ-009 Port cin, input, 1 bit, is the carry-in, used only by ADC and SBB.
REQ-010 Port op, input, 2 bits, selects the operation: op_e ADD=0, ADC=1, SUB=2, SBB=3.
REQ-011 Port out_valid, output, 1 bit, means the result is valid.
REQ-012 Port out_ready, input, 1 bit, means the consumer accepts the result.
REQ-013 Port sum, output, WIDTH bits, is the result.
REQ-014 Port flags, output, 4 bits, is {carry, overflow, zero, negative}.

Function
REQ-015 Arithmetic SHALL be: ADD = a+b; ADC = a+b+cin; SUB = a+~b+1; SBB = a+~b+cin. The result is modulo 2^WIDTH.
REQ-016 Carry SHALL be the raw adder carry-out; for SUB/SBB, 1 = no borrow.
REQ-017 Overflow SHALL be signed two's-complement overflow of the effective addition (operand signs equal, result sign differs).
REQ-018 Zero SHALL be (sum == 0); negative SHALL be sum[WIDTH-1].
REQ-019 Addition SHALL use GROUP-bit carry-lookahead groups (generate = a&b, propagate = a^b, group G/P) with a lookahead carry across groups within each half; no ripple across bit cells.
REQ-020 Stage 1 SHALL register the low WIDTH/2 sum bits, the low-half carry-out, the high-half operand bits (b already conditionally inverted), and op.
REQ-021 Stage 2 SHALL compute the high half from the registered low-half carry, form the flags, and register sum and flags as outputs.
REQ-022 A transfer SHALL occur on a valid&ready edge at each interface.
REQ-023 Latency SHALL be exactly 2 edges from input accept to out_valid with no stall; throughput SHALL be 1 op/cycle.
REQ-024 Backpressure: stage 2 SHALL advance when !out_valid or out_ready; stage 1 SHALL advance when stage 1 is empty or stage 2 advances.
REQ-025 in_ready SHALL equal the stage 1 advance condition, combinationally from out_ready, with no combinational path from in_valid.
REQ-026 When both stages are full and out_ready=0, the block SHALL hold 2 ops, in_ready=0, and sum/flags stable.
REQ-027 On simultaneous accept and output consume, the pipeline SHALL shift with no bubble.
REQ-028 Results SHALL emerge in acceptance order; no op is dropped or duplicated.
REQ-029 sum and flags SHALL change only when stage 2 loads.

Reset
REQ-030 While rst_n=0, both stage valids, out_valid, sum and flags SHALL be 0 asynchronously; in_ready SHALL be 1 after rst_n deasserts.
REQ-031 Reset mid-operation SHALL discard in-flight ops; no partial result is emitted.

Structure
REQ-032 Package alu_pkg SHALL hold typedef op_e, the flag index constants (FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_N=0), and GROUP_W=4.
REQ-033 Sub-module cla_group SHALL be a combinational 4-bit lookahead group with ports a, b, cin, sum, G, P, cout, instantiated WIDTH/4 times.

Verification
REQ-034 Scenario: WIDTH=8, ADD FF+01 -> sum 00, flags C1 V0 Z1 N0, out_valid 2 edges after accept.
REQ-035 Scenario: SUB 80-01 -> sum 7F, C1 V1 Z0 N0; and SUB 00-01 -> sum FF, C0 V0 N1.
REQ-036 Scenario: ADC 7F+00 with cin=1 -> sum 80, C0 V1 N1; and SBB 05-03 with cin=0 -> sum 01, C1.
REQ-037 Scenario: 3 back-to-back ops with out_ready=0 -> 2 accepted, in_ready=0 on the 3rd; after out_ready=1, results appear in order with no loss.
REQ-038 Scenario: both stages full, rst_n pulsed low -> out_valid=0 and sum=0 immediately; the next op completes correctly.
REQ-039 Scenario: WIDTH=32, 10k random ops with random in_valid/out_ready -> each result matches the arithmetic model with matching flags.
